// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding selection and pipeline-register
// enable control for a 5-stage RISC-V core. Tracks valid/rd/regwrite/memread for
// the EX, MEM and WB stages and derives stall, flush, freeze and forwarding selects
// combinationally from that state plus the ID-stage instruction.
// Optional feature: define PIPE_PERF_CNT_EN to add saturating stall/flush/freeze
// performance counters (ports stall_cnt, flush_cnt, freeze_cnt).
module pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  br_taken,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic [1:0]            fwd_id_a,
    output logic [1:0]            fwd_id_b,
    output logic [1:0]            fwd_ex_a,
    output logic [1:0]            fwd_ex_b
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      freeze_cnt
`endif
);

    // EX stage bookkeeping, including the source registers of the EX instruction.
    logic                  ex_v_q, ex_v_d;
    logic [RF_ADDRESS-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_mr_q, ex_mr_d;
    logic [RF_ADDRESS-1:0] ex_rs1_q, ex_rs1_d;
    logic [RF_ADDRESS-1:0] ex_rs2_q, ex_rs2_d;
    logic                  ex_use1_q, ex_use1_d;
    logic                  ex_use2_q, ex_use2_d;
    // MEM and WB stage bookkeeping.
    logic                  mem_v_q, mem_v_d;
    logic [RF_ADDRESS-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_rw_q, mem_rw_d;
    logic                  mem_mr_q, mem_mr_d;
    logic                  wb_v_q, wb_v_d;
    logic [RF_ADDRESS-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_rw_q, wb_rw_d;

    logic freeze, stall, flush;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic exs_mem_hit_a, exs_mem_hit_b, exs_wb_hit_a, exs_wb_hit_b;

    // A stage supplies a source only if it holds a live, non-x0 register write to it.
    function automatic logic src_hit(input logic                  v,
                                     input logic                  rw,
                                     input logic [RF_ADDRESS-1:0] rd,
                                     input logic [RF_ADDRESS-1:0] src,
                                     input logic                  en);
        return v & rw & (rd != '0) & (rd == src) & en;
    endfunction

    // Producer matches for the ID sources (EX, MEM) and the EX sources (MEM, WB).
    always_comb begin
        ex_hit_a      = src_hit(ex_v_q,  ex_rw_q,  ex_rd_q,  id_rs1,   id_use_rs1);
        ex_hit_b      = src_hit(ex_v_q,  ex_rw_q,  ex_rd_q,  id_rs2,   id_use_rs2);
        mem_hit_a     = src_hit(mem_v_q, mem_rw_q, mem_rd_q, id_rs1,   id_use_rs1);
        mem_hit_b     = src_hit(mem_v_q, mem_rw_q, mem_rd_q, id_rs2,   id_use_rs2);
        exs_mem_hit_a = src_hit(mem_v_q, mem_rw_q, mem_rd_q, ex_rs1_q, ex_use1_q);
        exs_mem_hit_b = src_hit(mem_v_q, mem_rw_q, mem_rd_q, ex_rs2_q, ex_use2_q);
        exs_wb_hit_a  = src_hit(wb_v_q,  wb_rw_q,  wb_rd_q,  ex_rs1_q, ex_use1_q);
        exs_wb_hit_b  = src_hit(wb_v_q,  wb_rw_q,  wb_rd_q,  ex_rs2_q, ex_use2_q);
    end

    // Hazard classification with freeze > stall > flush; reset masks all three.
    always_comb begin
        freeze = reset & mem_busy;
        stall  = reset & ~freeze & id_valid &
                 ((ex_mr_q & (ex_hit_a | ex_hit_b)) | (id_branch & (ex_hit_a | ex_hit_b)));
        flush  = reset & ~freeze & ~stall & id_valid & (id_jump | (id_branch & br_taken));
    end

    // Pipeline-register enables, bubble and flush.
    always_comb begin
        pc_en       = ~freeze & ~stall;
        ifid_en     = ~freeze & ~stall;
        ifid_flush  = flush;
        idex_en     = ~freeze;
        idex_bubble = stall;
        exmem_en    = ~freeze;
        memwb_en    = ~freeze;
    end

    // Forwarding selects for the ID comparator and the EX ALU operands.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fwd_id_a = 2'b00;
        fwd_id_b = 2'b00;
        fwd_ex_a = 2'b00;
        fwd_ex_b = 2'b00;
        if (ex_hit_a && !ex_mr_q)  fwd_id_a = 2'b10;
        else if (mem_hit_a)        fwd_id_a = mem_mr_q ? 2'b11 : 2'b01;
        if (ex_hit_b && !ex_mr_q)  fwd_id_b = 2'b10;
        else if (mem_hit_b)        fwd_id_b = mem_mr_q ? 2'b11 : 2'b01;
        if (exs_mem_hit_a)         fwd_ex_a = 2'b10;
        else if (exs_wb_hit_a)     fwd_ex_a = 2'b01;
        if (exs_mem_hit_b)         fwd_ex_b = 2'b10;
        else if (exs_wb_hit_b)     fwd_ex_b = 2'b01;
    end

    // Next bookkeeping state: hold while frozen, otherwise shift ID->EX->MEM->WB.
    always_comb begin
        ex_v_d    = ex_v_q;
        ex_rd_d   = ex_rd_q;
        ex_rw_d   = ex_rw_q;
        ex_mr_d   = ex_mr_q;
        ex_rs1_d  = ex_rs1_q;
        ex_rs2_d  = ex_rs2_q;
        ex_use1_d = ex_use1_q;
        ex_use2_d = ex_use2_q;
        mem_v_d   = mem_v_q;
        mem_rd_d  = mem_rd_q;
        mem_rw_d  = mem_rw_q;
        mem_mr_d  = mem_mr_q;
        wb_v_d    = wb_v_q;
        wb_rd_d   = wb_rd_q;
        wb_rw_d   = wb_rw_q;
        if (!freeze) begin
            ex_v_d    = id_valid & ~stall;
            ex_rd_d   = id_rd;
            ex_rw_d   = id_regwrite;
            ex_mr_d   = id_memread;
            ex_rs1_d  = id_rs1;
            ex_rs2_d  = id_rs2;
            // A bubble never requests forwarding.
            ex_use1_d = id_use_rs1 & id_valid & ~stall;
            ex_use2_d = id_use_rs2 & id_valid & ~stall;
            mem_v_d   = ex_v_q;
            mem_rd_d  = ex_rd_q;
            mem_rw_d  = ex_rw_q;
            mem_mr_d  = ex_mr_q;
            wb_v_d    = mem_v_q;
            wb_rd_d   = mem_rd_q;
            wb_rw_d   = mem_rw_q;
        end
    end

    // Stage bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: this state is a handful of flops, so all of it is reset; valid and rd
        // clear asynchronously so no stale producer survives a reset.
        if (!reset) begin
            ex_v_q    <= 1'b0;
            ex_rd_q   <= '0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
            mem_v_q   <= 1'b0;
            mem_rd_q  <= '0;
            mem_rw_q  <= 1'b0;
            mem_mr_q  <= 1'b0;
            wb_v_q    <= 1'b0;
            wb_rd_q   <= '0;
            wb_rw_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ex_v_q    <= ex_v_d;
            ex_rd_q   <= ex_rd_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
            mem_v_q   <= mem_v_d;
            mem_rd_q  <= mem_rd_d;
            mem_rw_q  <= mem_rw_d;
            mem_mr_q  <= mem_mr_d;
            wb_v_q    <= wb_v_d;
            wb_rd_q   <= wb_rd_d;
            wb_rw_q   <= wb_rw_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Saturating event counters, one increment per cycle of each condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall  && (stall_cnt_q  != '1)) stall_cnt_q  <= stall_cnt_q  + CNT_W'(1);
            if (flush  && (flush_cnt_q  != '1)) flush_cnt_q  <= flush_cnt_q  + CNT_W'(1);
            if (freeze && (freeze_cnt_q != '1)) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized instruction streams, all compared against an instruction-level model
// of the EX/MEM/WB occupancy. Counter checks apply when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int RF = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RF-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_regwrite, id_memread, id_branch, id_jump, br_taken, mem_busy;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
    logic [1:0]    fwd_id_a, fwd_id_b, fwd_ex_a, fwd_ex_b;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    pipe_hazard_ctrl #(.RF_ADDRESS(RF), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_branch(id_branch), .id_jump(id_jump), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic          v;
        logic [RF-1:0] rd;
        logic          rw;
        logic          mr;
        logic [RF-1:0] rs1;
        logic [RF-1:0] rs2;
        logic          u1;
        logic          u2;
    } instr_t;

    instr_t      pm [3];   // 0 = EX, 1 = MEM, 2 = WB
    bit          m_frz, m_stl, m_fl;
    int unsigned m_stall_cnt, m_flush_cnt, m_freeze_cnt;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(input instr_t r, input logic [RF-1:0] src, input logic en);
        return r.v && r.rw && (r.rd != 0) && (r.rd == src) && en;
    endfunction

    function automatic logic [1:0] exp_fwd_id(input logic [RF-1:0] src, input logic en);
        if (writes(pm[0], src, en) && !pm[0].mr) return 2'b10;
        if (writes(pm[1], src, en))              return pm[1].mr ? 2'b11 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_fwd_ex(input logic [RF-1:0] src, input logic en);
        if (writes(pm[1], src, en)) return 2'b10;
        if (writes(pm[2], src, en)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pm[i] = '0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
        m_freeze_cnt = 0;
    endtask

    // Settle, derive the expected hazard decision and compare every output.
    task automatic step(input string tag);
        bit dep;
        #1;
        if (!reset) begin
            m_frz = 0; m_stl = 0; m_fl = 0;
        end else begin
            dep   = writes(pm[0], id_rs1, id_use_rs1) || writes(pm[0], id_rs2, id_use_rs2);
            m_frz = mem_busy;
            m_stl = !m_frz && id_valid && dep && (pm[0].mr || id_branch);
            m_fl  = !m_frz && !m_stl && id_valid && (id_jump || (id_branch && br_taken));
        end
        chk({tag, ".pc_en"},       pc_en,       !m_frz && !m_stl);
        chk({tag, ".ifid_en"},     ifid_en,     !m_frz && !m_stl);
        chk({tag, ".ifid_flush"},  ifid_flush,  m_fl);
        chk({tag, ".idex_en"},     idex_en,     !m_frz);
        chk({tag, ".idex_bubble"}, idex_bubble, m_stl);
        chk({tag, ".exmem_en"},    exmem_en,    !m_frz);
        chk({tag, ".memwb_en"},    memwb_en,    !m_frz);
        chk({tag, ".fwd_id_a"},    fwd_id_a,    exp_fwd_id(id_rs1, id_use_rs1));
        chk({tag, ".fwd_id_b"},    fwd_id_b,    exp_fwd_id(id_rs2, id_use_rs2));
        chk({tag, ".fwd_ex_a"},    fwd_ex_a,    exp_fwd_ex(pm[0].rs1, pm[0].u1));
        chk({tag, ".fwd_ex_b"},    fwd_ex_b,    exp_fwd_ex(pm[0].rs2, pm[0].u2));
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".stall_cnt"},   stall_cnt,   16'(m_stall_cnt));
        chk({tag, ".flush_cnt"},   flush_cnt,   16'(m_flush_cnt));
        chk({tag, ".freeze_cnt"},  freeze_cnt,  16'(m_freeze_cnt));
`endif
    endtask

    // Clock edge: the model advances with the decision made in step().
    task automatic tick();
        instr_t nx;
        @(posedge clk);
        if (reset) begin
            if (m_stl && m_stall_cnt  < CNT_MAX) m_stall_cnt++;
            if (m_fl  && m_flush_cnt  < CNT_MAX) m_flush_cnt++;
            if (m_frz && m_freeze_cnt < CNT_MAX) m_freeze_cnt++;
            if (!m_frz) begin
                nx.v   = id_valid && !m_stl;
                nx.rd  = id_rd;
                nx.rw  = id_regwrite;
                nx.mr  = id_memread;
                nx.rs1 = id_rs1;
                nx.rs2 = id_rs2;
                nx.u1  = id_use_rs1 && nx.v;
                nx.u2  = id_use_rs2 && nx.v;
                pm[2]  = pm[1];
                pm[1]  = pm[0];
                pm[0]  = nx;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [RF-1:0] rs1, input logic [RF-1:0] rs2,
                         input logic u1, input logic u2, input logic [RF-1:0] rd,
                         input logic rw, input logic mr, input logic br, input logic jp,
                         input logic tk, input logic busy);
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd;    id_regwrite = rw; id_memread = mr;
        id_branch = br; id_jump = jp; br_taken = tk; mem_busy = busy;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("drain");
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("rst");
        chk("rst_pc_en", pc_en, 1);
        tick();
        reset = 1'b1;

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        drive(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); step("lu_lw"); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0); step("lu_stall");
        chk("lu_stall_pc_en", pc_en, 0);
        chk("lu_stall_bubble", idex_bubble, 1);
        tick();
        step("lu_go");
        chk("lu_go_pc_en", pc_en, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("lu_wb");
        chk("lu_wb_fwd_ex_a", fwd_ex_a, 2'b01);
        tick();
        drain();

        // ALU producer feeding a branch: addi x3 then beq x3,x0.
        drive(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0); step("ab_addi"); tick();
        drive(1, 3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0); step("ab_stall");
        chk("ab_stall_pc_en", pc_en, 0);
        tick();
        step("ab_go");
        chk("ab_go_pc_en", pc_en, 1);
        chk("ab_go_fwd_id_a", fwd_id_a, 2'b01);
        tick();
        drain();

        // Load producer feeding a branch: lw x3 then beq x3,x4.
        drive(1, 2, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0); step("lb_lw"); tick();
        drive(1, 3, 4, 1, 1, 0, 0, 0, 1, 0, 0, 0); step("lb_stall");
        chk("lb_stall_pc_en", pc_en, 0);
        tick();
        step("lb_go");
        chk("lb_go_fwd_id_a", fwd_id_a, 2'b11);
        tick();
        drain();

        // Taken bne held in ID while the data memory is busy for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1, 1); step("fz_busy");
            chk("fz_busy_flush", ifid_flush, 0);
            chk("fz_busy_pc_en", pc_en, 0);
            chk("fz_busy_memwb_en", memwb_en, 0);
            tick();
        end
        drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1, 0); step("fz_free");
        chk("fz_free_flush", ifid_flush, 1);
        chk("fz_free_pc_en", pc_en, 1);
`ifdef PIPE_PERF_CNT_EN
        chk("fz_freeze_cnt", freeze_cnt, 3);
`endif
        tick();
        drain();

        // Loads and ALU ops writing x0 everywhere, read back as x0 sources.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 1, 0, 1, i[0], 1, 0, 0, 0); step("x0");
            chk("x0_pc_en", pc_en, 1);
            chk("x0_fwd_id_a", fwd_id_a, 2'b00);
            chk("x0_fwd_ex_b", fwd_ex_b, 2'b00);
            tick();
        end
        drain();

        // Reset in the middle of a load-use stall.
        drive(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); step("rs_lw"); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0); step("rs_stall");
        chk("rs_stall_bubble", idex_bubble, 1);
        #1;
        reset = 1'b0;
        model_reset();
        step("rs_mid");
        chk("rs_mid_pc_en", pc_en, 1);
        chk("rs_mid_bubble", idex_bubble, 0);
        tick();
        reset = 1'b1;
        step("rs_after");
        chk("rs_after_pc_en", pc_en, 1);
        chk("rs_after_fwd_id_a", fwd_id_a, 2'b00);
        tick();

        // Randomized instruction streams over a small register set.
        for (int n = 0; n < 600; n++) begin
            logic rw, mr;
            reset = ($urandom_range(99) != 0);
            if (!reset) model_reset();
            rw = 1'($urandom_range(1));
            mr = rw & 1'($urandom_range(1));
            drive(($urandom_range(99) < 85), RF'($urandom_range(3)), RF'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), RF'($urandom_range(3)),
                  rw, mr, ($urandom_range(99) < 20), ($urandom_range(99) < 10),
                  1'($urandom_range(1)), ($urandom_range(99) < 15));
            step("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
